// File: rtl/mmio_access_unit_pkg.sv
// mmio_access_unit_pkg: physical IO memory map, register selects and timer types for the MMIO target
package mmio_access_unit_pkg;
  localparam int PHY_RAW_W = 30;
  localparam logic [PHY_RAW_W-1:0] PHY_TIMER_LO = 30'h0_0000;
  localparam logic [PHY_RAW_W-1:0] PHY_TIMER_HI = 30'h0_0004;
  localparam logic [PHY_RAW_W-1:0] PHY_CMP_LO = 30'h0_0008;
  localparam logic [PHY_RAW_W-1:0] PHY_CMP_HI = 30'h0_000C;
  localparam logic [PHY_RAW_W-1:0] PHY_SERIAL = 30'h0_2000;
  typedef logic [63:0] TimerPath;
  typedef struct packed {
    logic isUncachable;
    logic isIO;
    logic [PHY_RAW_W-1:0] raw;
  } PhyAddrPath;
  typedef enum logic [2:0] {TIMER_LO, TIMER_HI, CMP_LO, CMP_HI, SERIAL, NONE} MmioRegSel;
  function automatic MmioRegSel decode_sel(input logic is_io, input logic [PHY_RAW_W-1:0] raw);
    return !is_io ? NONE :
           raw == PHY_TIMER_LO ? TIMER_LO :
           raw == PHY_TIMER_HI ? TIMER_HI :
           raw == PHY_CMP_LO ? CMP_LO :
           raw == PHY_CMP_HI ? CMP_HI :
           raw == PHY_SERIAL ? SERIAL : NONE;
  endfunction
endpackage

// File: rtl/mmio_access_unit_serial_out_fifo.sv
// serial_out_fifo: circular byte FIFO with read/write pointers and occupancy count
module serial_out_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [7:0] push_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= push_data;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign head = count != '0 ? mem[rd_ptr] : 8'h00;
endmodule

// File: rtl/mmio_access_unit.sv
// mmio_access_unit: IO target for the machine timer/compare registers and the serial output FIFO
module mmio_access_unit
  import mmio_access_unit_pkg::*;
#(
  parameter int SERIAL_FIFO_DEPTH = 4,
  parameter int TIMER_PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic reqValid,
  output logic reqReady,
  input  logic reqIsWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWriteData,
  output logic rspValid,
  output logic [31:0] rspData,
  output logic rspError,
  output logic serialValid,
  output logic [7:0] serialData,
  input  logic serialReady,
  output logic timerInterrupt
);
  localparam int CW = $clog2(SERIAL_FIFO_DEPTH) + 1;
  localparam int PW = TIMER_PRESCALE > 1 ? $clog2(TIMER_PRESCALE) : 1;
  PhyAddrPath addr;
  MmioRegSel sel;
  logic unused_uncachable;
  logic [CW-1:0] count;
  logic accept, wr, push, pop, tick;
  logic [PW-1:0] prescale;
  TimerPath mtime, mtimecmp, mtime_inc, mtime_nxt, cmp_nxt;
  logic [31:0] rd_data;
  assign addr = reqAddr;
  assign unused_uncachable = addr.isUncachable;
  assign sel = decode_sel(addr.isIO, addr.raw);
  // Full check uses the registered count so a same-cycle pop never opens the gate early
  assign reqReady = !(reqIsWrite && sel == SERIAL && count == CW'(SERIAL_FIFO_DEPTH));
  assign accept = reqValid && reqReady;
  assign wr = accept && reqIsWrite;
  assign push = wr && sel == SERIAL;
  assign serialValid = count != '0;
  assign pop = serialValid && serialReady;
  assign tick = prescale == PW'(TIMER_PRESCALE - 1);
  assign mtime_inc = tick ? mtime + 64'd1 : mtime;
  // A half-write replaces the increment; the untouched half stays at its pre-increment value
  assign mtime_nxt = wr && sel == TIMER_LO ? {mtime[63:32], reqWriteData} :
                     wr && sel == TIMER_HI ? {reqWriteData, mtime[31:0]} : mtime_inc;
  assign cmp_nxt = wr && sel == CMP_LO ? {mtimecmp[63:32], reqWriteData} :
                   wr && sel == CMP_HI ? {reqWriteData, mtimecmp[31:0]} : mtimecmp;
  assign rd_data = reqIsWrite ? 32'h0 :
                   sel == TIMER_LO ? mtime[31:0] :
                   sel == TIMER_HI ? mtime[63:32] :
                   sel == CMP_LO ? mtimecmp[31:0] :
                   sel == CMP_HI ? mtimecmp[63:32] :
                   sel == SERIAL ? {24'h0, 8'(count)} : 32'h0;
  serial_out_fifo #(.DEPTH(SERIAL_FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .push_data(reqWriteData[7:0]),
    .count(count),
    .head(serialData)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rspValid <= 1'b0;
      rspData <= '0;
      rspError <= 1'b0;
      timerInterrupt <= 1'b0;
      mtime <= '0;
      mtimecmp <= '1;
      prescale <= '0;
    end else begin
      rspValid <= accept;
      rspData <= accept ? rd_data : 32'h0;
      rspError <= accept && sel == NONE;
      timerInterrupt <= mtime_nxt >= cmp_nxt;
      mtime <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      prescale <= tick ? '0 : prescale + PW'(1);
    end
  end
endmodule

// File: tb/tb_mmio_access_unit.sv
// tb_mmio_access_unit: scoreboard bench for the MMIO timer and serial FIFO target
module tb_mmio_access_unit;
  typedef struct packed {
    logic [31:0] data;
    logic err;
  } rsp_t;
  localparam logic [31:0] A_MTL = 32'h4000_0000;
  localparam logic [31:0] A_MTH = 32'h4000_0004;
  localparam logic [31:0] A_CML = 32'h4000_0008;
  localparam logic [31:0] A_CMH = 32'h4000_000C;
  localparam logic [31:0] A_SER = 32'h4000_2000;
  logic clk = 0, rst = 1, reqValid = 0, reqIsWrite = 0, serialReady = 0;
  logic [31:0] reqAddr = 0, reqWriteData = 0;
  logic reqReady, rspValid, rspError, serialValid, timerInterrupt;
  logic [31:0] rspData;
  logic [7:0] serialData;
  int compared = 0, mismatched = 0;
  rsp_t rsp_q[$];
  logic [7:0] ser_q[$];
  rsp_t exp_r;
  logic [7:0] exp_b;

  mmio_access_unit #(.SERIAL_FIFO_DEPTH(4), .TIMER_PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .reqIsWrite(reqIsWrite), .reqAddr(reqAddr), .reqWriteData(reqWriteData),
    .rspValid(rspValid), .rspData(rspData), .rspError(rspError),
    .serialValid(serialValid), .serialData(serialData), .serialReady(serialReady),
    .timerInterrupt(timerInterrupt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && rspValid) begin
    compared++;
    if (rsp_q.size() == 0) begin
      mismatched++;
      $display("FAIL rsp_unexpected: got data=%h err=%b, required no response", rspData, rspError);
    end else begin
      exp_r = rsp_q.pop_front();
      if (rspData !== exp_r.data || rspError !== exp_r.err) begin
        mismatched++;
        $display("FAIL rsp: got data=%h err=%b, required data=%h err=%b", rspData, rspError, exp_r.data, exp_r.err);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst && serialValid && serialReady) begin
      compared++;
      if (ser_q.size() == 0) begin
        mismatched++;
        $display("FAIL serial_unexpected: got byte %h, required none", serialData);
      end else begin
        exp_b = ser_q.pop_front();
        if (serialData !== exp_b) begin
          mismatched++;
          $display("FAIL serial_byte: got %h, required %h", serialData, exp_b);
        end
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ed, input logic ee);
    int n = 0;
    reqValid = 1; reqIsWrite = w; reqAddr = a; reqWriteData = d;
    #1;
    while (!reqReady && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!reqReady) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: reqReady=%b, required 1 within 50 cycles", reqReady);
    end else begin
      rsp_q.push_back('{ed, ee});
      if (w && a == A_SER) ser_q.push_back(d[7:0]);
    end
    @(negedge clk);
    reqValid = 0;
  endtask

  task automatic check_irq(input string name, input logic e);
    compared++;
    if (timerInterrupt !== e) begin
      mismatched++;
      $display("FAIL %s: timerInterrupt=%b, required %b", name, timerInterrupt, e);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    compared++;
    if (rspValid !== 0 || rspData !== 0 || rspError !== 0 || reqReady !== 1) begin
      mismatched++;
      $display("FAIL reset_rsp: valid=%b data=%h err=%b ready=%b, required 0 0 0 1", rspValid, rspData, rspError, reqReady);
    end
    compared++;
    if (serialValid !== 0 || serialData !== 0 || timerInterrupt !== 0) begin
      mismatched++;
      $display("FAIL reset_out: sv=%b sd=%h irq=%b, required 0 00 0", serialValid, serialData, timerInterrupt);
    end
    rst = 0;
    repeat (10) @(negedge clk);
    send(0, A_MTL, 0, 32'd10, 0);
    check_irq("irq_after_idle", 0);
  endtask

  task automatic test_timer_carry;
    send(1, A_MTH, 32'h0, 0, 0);
    send(1, A_MTL, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk);
    send(0, A_MTL, 0, 32'h0, 0);
    send(0, A_MTH, 0, 32'h1, 0);
  endtask

  task automatic test_interrupt;
    send(1, A_MTH, 32'h0, 0, 0);
    send(1, A_MTL, 32'h0, 0, 0);
    send(1, A_CMH, 32'h0, 0, 0);
    send(1, A_CML, 32'd5, 0, 0);
    check_irq("irq_mtime2", 0);
    repeat (2) @(negedge clk);
    check_irq("irq_mtime4", 0);
    @(negedge clk);
    check_irq("irq_mtime5", 1);
    send(1, A_CML, 32'hFFFF_FFFF, 0, 0);
    check_irq("irq_fall", 0);
    send(0, A_MTL, 0, 32'd6, 0);
    send(0, A_CML, 0, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_serial;
    int n = 0;
    serialReady = 0;
    for (int i = 0; i < 4; i++) send(1, A_SER, 32'h41 + i, 0, 0);
    send(0, A_SER, 0, 32'd4, 0);
    compared++;
    if (serialValid !== 1 || serialData !== 8'h41) begin
      mismatched++;
      $display("FAIL serial_head: sv=%b sd=%h, required 1 41", serialValid, serialData);
    end
    reqValid = 1; reqIsWrite = 1; reqAddr = A_SER; reqWriteData = 32'h45;
    repeat (3) begin
      #1;
      compared++;
      if (reqReady !== 0) begin
        mismatched++;
        $display("FAIL full_stall: reqReady=%b, required 0", reqReady);
      end
      @(negedge clk);
    end
    serialReady = 1;
    #1;
    compared++;
    if (reqReady !== 0) begin
      mismatched++;
      $display("FAIL no_pop_bypass: reqReady=%b, required 0", reqReady);
    end
    @(negedge clk);
    #1;
    compared++;
    if (reqReady !== 1) begin
      mismatched++;
      $display("FAIL ready_after_pop: reqReady=%b, required 1", reqReady);
    end else begin
      rsp_q.push_back('{32'h0, 1'b0});
      ser_q.push_back(8'h45);
    end
    @(negedge clk);
    reqValid = 0;
    while (ser_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #3;
    compared++;
    if (ser_q.size() != 0 || serialValid !== 0) begin
      mismatched++;
      $display("FAIL serial_drain: left=%0d sv=%b, required 0 0", ser_q.size(), serialValid);
    end
    @(negedge clk);
  endtask

  task automatic test_errors;
    send(0, 32'h0000_0000, 0, 0, 1);
    send(0, 32'h4000_0010, 0, 0, 1);
    send(1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 1);
    send(1, 32'h0000_2000, 32'h55, 0, 1);
    send(0, A_MTH, 0, 32'h0, 0);
    send(0, A_SER, 0, 32'h0, 0);
    compared++;
    if (serialValid !== 0) begin
      mismatched++;
      $display("FAIL err_no_push: sv=%b, required 0", serialValid);
    end
  endtask

  task automatic test_reset_mid;
    serialReady = 0;
    for (int i = 0; i < 3; i++) send(1, A_SER, 32'h61 + i, 0, 0);
    reqValid = 1; reqIsWrite = 0; reqAddr = A_MTL;
    @(posedge clk);
    #1;
    reqValid = 0;
    compared++;
    if (rspValid !== 1 || serialValid !== 1) begin
      mismatched++;
      $display("FAIL pre_reset: rv=%b sv=%b, required 1 1", rspValid, serialValid);
    end
    rst = 1;
    #1;
    rsp_q.delete();
    ser_q.delete();
    compared++;
    if (rspValid !== 0 || serialValid !== 0 || serialData !== 0) begin
      mismatched++;
      $display("FAIL mid_reset: rv=%b sv=%b sd=%h, required 0 0 00", rspValid, serialValid, serialData);
    end
    @(negedge clk);
    rst = 0;
    send(0, A_MTL, 0, 32'h0, 0);
    send(0, A_SER, 0, 32'h0, 0);
    send(0, A_CMH, 0, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_back_to_back;
    send(1, A_CMH, 32'h1234_5678, 0, 0);
    send(1, A_CML, 32'h9ABC_DEF0, 0, 0);
    send(0, A_CMH, 0, 32'h1234_5678, 0);
    send(0, A_CML, 0, 32'h9ABC_DEF0, 0);
    send(0, 32'hC000_0004, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    compared++;
    if (rsp_q.size() != 0 || ser_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: rsp=%0d ser=%0d, required 0 0", rsp_q.size(), ser_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_timer_carry();
    test_interrupt();
    test_serial();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
